// File: rtl/regfile_pkg.sv
// Shared defaults and data type for the register file with scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;

    typedef logic [XLEN_DEF-1:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: per-register busy bits, issue acceptance and an
// incrementally maintained count of busy registers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  NREGS = NREGS_DEF,
    localparam int IDXW  = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_idx,
    input  logic             iss_en,
    input  logic [IDXW-1:0]  iss_idx,
    output logic [NREGS-1:0] busy,
    output logic             iss_ready,
    output logic [IDXW:0]    busy_cnt
);

    localparam logic [IDXW:0] CNT_ONE = {{IDXW{1'b0}}, 1'b1};

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [IDXW:0]    cnt_q;
    logic             iss_fire;
    logic             wr_clr;
    logic             cnt_inc;
    logic             cnt_dec;

    // A write to the issuing index frees the slot in the same cycle.
    assign iss_ready = !busy_q[iss_idx] || (wr_en && (wr_idx == iss_idx));
    assign iss_fire  = iss_en && iss_ready && (iss_idx != '0);
    assign wr_clr    = wr_en && (wr_idx != '0) && !(iss_fire && (iss_idx == wr_idx));

    // Same-index issue+write leaves the bit set and the count unchanged.
    assign cnt_inc = iss_fire && !busy_q[iss_idx];
    assign cnt_dec = wr_clr && busy_q[wr_idx];

    always_comb begin
        busy_d = busy_q;
        if (wr_clr) begin
            busy_d[wr_idx] = 1'b0;
        end
        if (iss_fire) begin
            busy_d[iss_idx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            if (cnt_inc && !cnt_dec) begin
                cnt_q <= cnt_q + CNT_ONE;
            end else if (cnt_dec && !cnt_inc) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with an attached pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to reads.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEF,
    parameter int  NREGS = NREGS_DEF,
    parameter int  NRD   = NRD_DEF,
    localparam int IDXW  = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*IDXW-1:0] rd_idx,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [IDXW-1:0]     wr_idx,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [IDXW-1:0]     iss_idx,
    output logic                iss_ready,
    output logic [IDXW:0]       busy_cnt
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .iss_en    (iss_en),
        .iss_idx   (iss_idx),
        .busy      (busy),
        .iss_ready (iss_ready),
        .busy_cnt  (busy_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_idx != '0)) begin
            regs[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            if (rd_idx[p*IDXW +: IDXW] != '0) begin
                rd_data[p*XLEN +: XLEN] = regs[rd_idx[p*IDXW +: IDXW]];
                rd_busy[p]              = busy[rd_idx[p*IDXW +: IDXW]];
`ifdef REGFILE_BYPASS_EN
                if (wr_en && (wr_idx == rd_idx[p*IDXW +: IDXW])) begin
                    rd_data[p*XLEN +: XLEN] = wr_data;
                    rd_busy[p]              = 1'b0;
                end
`endif
            end
        end
    end

endmodule
